// File: rtl/hash_pkg.sv
// Shared constants, FSM/phase types and command helpers
// for the demo_hash_core command sequencer.
package hash_pkg;

   localparam logic [3:0] SHA3_256  = 4'd0;
   localparam logic [3:0] SHA3_512  = 4'd1;
   localparam logic [3:0] SHAKE_128 = 4'd2;
   localparam logic [3:0] SHAKE_256 = 4'd3;
   localparam logic [3:0] SHA3_224  = 4'd4;
   localparam logic [3:0] SHA3_384  = 4'd5;

   localparam logic [15:0] CMD_INIT   = 16'h0800;
   localparam logic [15:0] CMD_PAD    = 16'h2000;
   localparam logic [15:0] CMD_SQZ    = 16'h1000;
   localparam logic [3:0]  ABS_NIBBLE = 4'h4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_STRM,
      ST_WAITLO,
      ST_WAITHI,
      ST_FIN
   } state_e;

   typedef enum logic [1:0] {
      PH_INIT,
      PH_ABSORB,
      PH_PAD,
      PH_SQZ
   } phase_e;

   function automatic logic is_xof(input logic [3:0] mode);
      case (mode)
         SHAKE_128, SHAKE_256:                   is_xof = 1'b1;
         SHA3_256, SHA3_512, SHA3_224, SHA3_384: is_xof = 1'b0;
         default:                                is_xof = 1'b0;
      endcase
   endfunction

   function automatic logic [19:0] phase_cmd(
      input phase_e      ph,
      input logic [3:0]  m,
      input logic [10:0] len
   );
      case (ph)
         PH_INIT:   phase_cmd = {CMD_INIT, m};
         PH_ABSORB: phase_cmd = {ABS_NIBBLE, 1'b0, len, m};
         PH_PAD:    phase_cmd = {CMD_PAD, m};
         default:   phase_cmd = {CMD_SQZ, m};
      endcase
   endfunction

endpackage

// File: rtl/hash_seq_ctrl_if.sv
// Host request/status and hash-core command signals
// of the sequencer, bundled for the top-level port.
interface hash_seq_ctrl_if;

   logic        start;
   logic        abort;
   logic [3:0]  mode;
   logic [10:0] inlen;
   logic [7:0]  nsqueeze;
   logic        core_done;
   logic [19:0] args;
   logic        strm_rst;
   logic        busy;
   logic        seq_done;
   logic        err;

   modport master (
      output start, abort, mode, inlen, nsqueeze, core_done,
      input  args, strm_rst, busy, seq_done, err
   );

   modport slave (
      input  start, abort, mode, inlen, nsqueeze, core_done,
      output args, strm_rst, busy, seq_done, err
   );

endinterface

// File: rtl/hash_done_waiter.sv
// Tracks the core's done low/high handshake and bounds the
// combined wait with a timeout counter.
module hash_done_waiter #(
   parameter int TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_lo_i,
   input  logic wait_hi_i,
   input  logic core_done_i,
   output logic ok_o,
   output logic timeout_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          waiting;

   always_comb begin
      waiting   = wait_lo_i | wait_hi_i;
      ok_o      = (wait_lo_i & ~core_done_i) | (wait_hi_i & core_done_i);
      timeout_o = waiting & ~ok_o & (tmr_q == TW'(TIMEOUT - 1));
      tmr_d     = tmr_q + TW'(1);
      // runs on through WAITLO->WAITHI, restarts once the wait is over
      if (!waiting || timeout_o || (wait_hi_i && ok_o))
         tmr_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end

endmodule

// File: rtl/hash_seq_ctrl.sv
// Drives demo_hash_core through init, absorb, pad and
// squeeze commands, pacing each phase on the core's done flag.
module hash_seq_ctrl
   import hash_pkg::*;
#(
   parameter int CMD_HOLD  = 10,
   parameter int RST_PULSE = 10,
   parameter int TIMEOUT   = 65535
) (
   input logic           clk,
   input logic           rst,
   hash_seq_ctrl_if.slave bus
);

   localparam int HMAX = (CMD_HOLD > RST_PULSE) ? CMD_HOLD : RST_PULSE;
   localparam int CW   = $clog2(HMAX + 1);

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    mode_q, mode_d;
   logic [10:0]   len_q, len_d;
   logic [7:0]    blk_q, blk_d;
   logic          err_q, err_d;
   logic [19:0]   args_q, args_d;
   logic          strm_q, strm_d;
   logic          busy_q, busy_d;
   logic          sdone_q, sdone_d;
   logic          ok, tmo;

   hash_done_waiter #(.TIMEOUT(TIMEOUT)) u_wait (
      .clk        (clk),
      .rst        (rst),
      .wait_lo_i  (state_q == ST_WAITLO),
      .wait_hi_i  (state_q == ST_WAITHI),
      .core_done_i(bus.core_done),
      .ok_o       (ok),
      .timeout_o  (tmo)
   );

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      len_d   = len_q;
      blk_d   = blk_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               mode_d  = bus.mode;
               len_d   = bus.inlen;
               blk_d   = (is_xof(bus.mode) && bus.nsqueeze != 8'd0)
                       ? bus.nsqueeze : 8'd1;
               err_d   = 1'b0;
               phase_d = PH_INIT;
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == CW'(CMD_HOLD - 1)) begin
               cnt_d = '0;
               unique case (phase_q)
                  PH_INIT:   phase_d = PH_ABSORB;
                  PH_ABSORB: state_d = ST_STRM;
                  default:   state_d = ST_WAITLO;
               endcase
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STRM: begin
            if (cnt_q == CW'(RST_PULSE - 1)) begin
               cnt_d   = '0;
               state_d = ST_WAITLO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAITLO: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (ok) begin
               state_d = ST_WAITHI;
            end
         end
         ST_WAITHI: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (ok) begin
               state_d = ST_ISSUE;
               unique case (phase_q)
                  PH_ABSORB: phase_d = PH_PAD;
                  PH_PAD:    phase_d = PH_SQZ;
                  default: begin
                     blk_d = blk_q - 8'd1;
                     if (blk_d == 8'd0) state_d = ST_FIN;
                  end
               endcase
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         err_d   = err_q;
         cnt_d   = '0;
      end
      // outputs are the registered decode of the next state
      args_d  = (state_d == ST_ISSUE) ? phase_cmd(phase_d, mode_d, len_d)
                                      : {16'h0000, mode_d};
      strm_d  = (state_d == ST_STRM);
      busy_d  = (state_d != ST_IDLE);
      sdone_d = (state_d == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= PH_INIT;
         cnt_q   <= '0;
         mode_q  <= 4'd0;
         len_q   <= 11'd0;
         blk_q   <= 8'd0;
         err_q   <= 1'b0;
         args_q  <= 20'd0;
         strm_q  <= 1'b0;
         busy_q  <= 1'b0;
         sdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         blk_q   <= blk_d;
         err_q   <= err_d;
         args_q  <= args_d;
         strm_q  <= strm_d;
         busy_q  <= busy_d;
         sdone_q <= sdone_d;
      end
   end

   assign bus.args     = args_q;
   assign bus.strm_rst = strm_q;
   assign bus.busy     = busy_q;
   assign bus.seq_done = sdone_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// Randomised bench for hash_seq_ctrl with a behavioural core
// model and a command-trace reference model.
module tb_hash_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hash_seq_ctrl_if bus();

   hash_seq_ctrl #(
      .CMD_HOLD (10),
      .RST_PULSE(10),
      .TIMEOUT  (50)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [3:0] last_m = 4'd0;

   typedef struct {
      logic [19:0] a;
      logic        b;
      logic        r;
      logic        d;
      logic        e;
      logic        c;
   } smp_t;

   smp_t tr[$];
   bit   rec = 0;

   always @(negedge clk)
      if (rec)
         tr.push_back('{bus.args, bus.busy, bus.strm_rst,
                        bus.seq_done, bus.err, bus.core_done});

   // core model: done drops a few cycles after each new command
   // and rises 20+ cycles later; hang keeps it high after PAD
   bit          hang = 0;
   bit          pad_cmd = 0;
   int          cyc = 0;
   int          drop_at = -1;
   int          rise_at = -1;
   logic [19:0] prev = 20'd0;

   always @(posedge clk) begin
      #2;
      cyc++;
      if (bus.args != prev && bus.args[19:4] != 16'h0) begin
         drop_at = cyc + int'($urandom_range(2, 4));
         rise_at = drop_at + int'($urandom_range(20, 26));
         pad_cmd = (bus.args[19:4] == 16'h2000);
      end
      prev = bus.args;
      if (cyc == 1)               bus.core_done = 1'b1;
      else if (hang && pad_cmd)   bus.core_done = 1'b1;
      else if (cyc == drop_at)    bus.core_done = 1'b0;
      else if (cyc == rise_at)    bus.core_done = 1'b1;
   end

   task automatic run_seq(input string nm, input logic [3:0] m,
                          input logic [10:0] len, input logic [7:0] nsq);
      logic [19:0] exp[$];
      logic [19:0] rv[$];
      int rs[$];
      int rl[$];
      int nb, n, first, nstrm, nsd, sdi, hs;
      nb = (m == 4'd2 || m == 4'd3) ? ((nsq == 8'd0) ? 1 : int'(nsq)) : 1;
      exp.push_back({16'h0800, m});
      exp.push_back({4'h4, 1'b0, len, m});
      exp.push_back({16'h0000, m});
      exp.push_back({16'h2000, m});
      exp.push_back({16'h0000, m});
      for (int i = 0; i < nb; i++) begin
         exp.push_back({16'h1000, m});
         exp.push_back({16'h0000, m});
      end
      tr.delete();
      rec = 1;
      bus.mode = m; bus.inlen = len; bus.nsqueeze = nsq;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      last_m = m;
      checks++;
      if (bus.busy !== 1'b1 || bus.args !== {16'h0800, m}) begin
         errors++;
         $display("FAIL %s start: busy=%b args=%h, required busy=1 args=%h",
                  nm, bus.busy, bus.args, {16'h0800, m});
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s finish: busy=%b after %0d cycles, required 0",
                  nm, bus.busy, n);
      end
      @(negedge clk);
      rec = 0;
      first = -1;
      for (int i = 0; i < tr.size(); i++)
         if (first < 0 && tr[i].b === 1'b1) first = i;
      if (first < 0) first = 0;
      for (int i = first; i < tr.size(); i++) begin
         if (rv.size() == 0 || tr[i].a !== rv[rv.size()-1]) begin
            rv.push_back(tr[i].a);
            rs.push_back(i);
            rl.push_back(1);
         end else begin
            rl[rl.size()-1]++;
         end
      end
      checks++;
      if (rv.size() != exp.size()) begin
         errors++;
         $display("FAIL %s cmd_count: got %0d args runs, required %0d",
                  nm, rv.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < rv.size(); i++) begin
         checks++;
         if (rv[i] !== exp[i]) begin
            errors++;
            $display("FAIL %s cmd[%0d]: args=%h, required %h",
                     nm, i, rv[i], exp[i]);
         end
         if (exp[i][19:4] != 16'h0) begin
            checks++;
            if (rl[i] != 10) begin
               errors++;
               $display("FAIL %s hold[%0d]: held %0d cycles, required 10",
                        nm, i, rl[i]);
            end
         end
      end
      nstrm = 0; nsd = 0; sdi = -1;
      for (int i = 0; i < tr.size(); i++) begin
         if (tr[i].r === 1'b1) nstrm++;
         if (tr[i].d === 1'b1) begin
            nsd++;
            sdi = i;
         end
      end
      checks++;
      if (nstrm != 10) begin
         errors++;
         $display("FAIL %s strm_rst: high %0d cycles, required 10", nm, nstrm);
      end
      checks++;
      if (nsd != 1) begin
         errors++;
         $display("FAIL %s seq_done: %0d pulse cycles, required 1", nm, nsd);
      end
      checks++;
      if (sdi < 0 || sdi + 1 >= tr.size() ||
          tr[sdi].b !== 1'b1 || tr[sdi+1].b !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_fall: seq_done index %0d, required busy 1 then 0",
                  nm, sdi);
      end
      hs = 0;
      for (int j = 1; j < rv.size(); j++) begin
         if (rv[j][19:4] == 16'h2000 || rv[j][19:4] == 16'h1000) begin
            bit lo = 0;
            bit hi = 0;
            for (int k = rs[j-1]; k < rs[j]; k++) begin
               if (tr[k].c === 1'b0) lo = 1;
               else if (lo && tr[k].c === 1'b1) hi = 1;
            end
            if (hi) hs++;
         end
      end
      checks++;
      if (hs != nb + 1) begin
         errors++;
         $display("FAIL %s handshake: %0d paced commands, required %0d",
                  nm, hs, nb + 1);
      end
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("FAIL %s err: err=%b, required 0", nm, bus.err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.args !== 20'd0 || bus.busy !== 1'b0 || bus.strm_rst !== 1'b0 ||
          bus.seq_done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset: args=%h busy=%b strm=%b sdone=%b err=%b, required all 0",
                  bus.args, bus.busy, bus.strm_rst, bus.seq_done, bus.err);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.args !== 20'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: args=%h busy=%b, required 0 0",
                  bus.args, bus.busy);
      end
   endtask

   task automatic test_sha3();
      run_seq("sha3_256", 4'd0, 11'h020, 8'($urandom_range(0, 255)));
      run_seq("sha3_224_len0", 4'd4, 11'd0, 8'd7);
   endtask

   task automatic test_xof();
      run_seq("shake128_n3", 4'd2, 11'h022, 8'd3);
      run_seq("shake256_n0", 4'd3, 11'h7ff, 8'd0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_seq("random", 4'($urandom_range(0, 15)),
                 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 4)));
   endtask

   task automatic test_timeout();
      int n, p, e, f, nsd;
      hang = 1;
      tr.delete();
      rec = 1;
      bus.mode = 4'd3; bus.inlen = 11'h010; bus.nsqueeze = 8'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      last_m = 4'd3;
      n = 0;
      while (bus.busy === 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b1 || bus.args !== 20'h00003) begin
         errors++;
         $display("FAIL timeout_state: busy=%b err=%b args=%h, required 0 1 00003",
                  bus.busy, bus.err, bus.args);
      end
      @(negedge clk);
      rec = 0;
      p = -1; e = -1; f = -1; nsd = 0;
      for (int i = 0; i < tr.size(); i++) begin
         if (p < 0 && tr[i].a === 20'h20003) p = i;
         if (p >= 0 && e < 0 && i > p && tr[i].a[19:4] === 16'h0) e = i;
         if (f < 0 && tr[i].e === 1'b1) f = i;
         if (tr[i].d === 1'b1) nsd++;
      end
      checks++;
      if (p < 0 || e < 0 || f < 0 || f - e < 49 || f - e > 51) begin
         errors++;
         $display("FAIL timeout_time: err after %0d wait cycles, required about 50",
                  f - e);
      end
      checks++;
      if (nsd != 0) begin
         errors++;
         $display("FAIL timeout_sdone: %0d seq_done cycles, required 0", nsd);
      end
      hang = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL err_clear: err=%b busy=%b, required 0 1", bus.err, bus.busy);
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL after_timeout_run: busy=%b err=%b, required 0 0",
                  bus.busy, bus.err);
      end
   endtask

   task automatic test_abort();
      int n, seen;
      bus.mode = 4'd1; bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.args !== {16'h0000, last_m}) begin
         errors++;
         $display("FAIL start_abort_idle: busy=%b args=%h, required 0 %h",
                  bus.busy, bus.args, {16'h0000, last_m});
      end
      bus.mode = 4'd1; bus.inlen = 11'h055;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      last_m = 4'd1;
      n = 0; seen = 0;
      while (seen < 4 && n < 200) begin
         if (bus.strm_rst === 1'b1) seen++;
         if (seen < 4) @(negedge clk);
         n++;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (seen != 4 || bus.strm_rst !== 1'b0 || bus.busy !== 1'b0 ||
          bus.args !== 20'h00001 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL abort_strm: pulses=%0d strm=%b busy=%b args=%h err=%b, required 4 0 0 00001 0",
                  seen, bus.strm_rst, bus.busy, bus.args, bus.err);
      end
      repeat (2) @(negedge clk);
      run_seq("rerun_after_abort", 4'd1, 11'h055, 8'd0);
   endtask

   task automatic test_start_hold_rst();
      int n;
      bit bad;
      tr.delete();
      rec = 1;
      bus.mode = 4'd5; bus.inlen = 11'h033; bus.nsqueeze = 8'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.mode = 4'd2; bus.inlen = 11'h444;
      checks++;
      if (bus.busy !== 1'b1 || bus.args !== 20'h08005) begin
         errors++;
         $display("FAIL hold_start: busy=%b args=%h, required 1 08005",
                  bus.busy, bus.args);
      end
      n = 0;
      while (bus.args !== 20'h20005 && n < 300) begin
         @(negedge clk);
         n++;
      end
      while (!(bus.args === 20'h00005 && bus.core_done === 1'b0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      rec = 0;
      bad = (n >= 400);
      for (int i = 0; i < tr.size(); i++)
         if (tr[i].b === 1'b1 && tr[i].a[3:0] !== 4'd5) bad = 1;
      checks++;
      if (bad || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL no_relatch: busy=%b args=%h reached=%0d, required mode nibble 5 throughout",
                  bus.busy, bus.args, n);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.args !== 20'd0 || bus.busy !== 1'b0 || bus.strm_rst !== 1'b0 ||
          bus.seq_done !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL rst_waithi: args=%h busy=%b strm=%b sdone=%b err=%b, required all 0",
                  bus.args, bus.busy, bus.strm_rst, bus.seq_done, bus.err);
      end
      bus.start = 1'b0;
      rst = 1'b0;
      last_m = 4'd0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mode = 4'd0;
      bus.inlen = 11'd0;
      bus.nsqueeze = 8'd0;
      test_reset();
      test_sha3();
      test_xof();
      test_timeout();
      test_abort();
      test_random();
      test_start_hold_rst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
